// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared memory.
// Optional build macro ILLEGAL_OP_HALT_EN makes an illegal opcode halt the controller until reset.
module multicycle_controller #(
    parameter int ALU_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_load,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [ALU_W-1:0] alu_cntrl,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_R_EXEC  = 4'd2,
        S_R_WB    = 4'd3,
        S_ADDR    = 4'd4,
        S_MEM_RD  = 4'd5,
        S_LW_WB   = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_I_EXEC  = 4'd9,
        S_I_WB    = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13,
        S_ILLEGAL = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b110);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b111);

    state_t state;

    // Memory handshake: a request (mem_read/mem_write) stays asserted while the FSM
    // holds its state; the access completes in the cycle mem_ready is sampled high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:        state <= (func == FN_JR) ? S_JR : S_R_EXEC;
                        OP_LW, OP_SW:    state <= S_ADDR;
                        OP_BEQ, OP_BNE:  state <= S_BRANCH;
                        OP_ADDI, OP_SLTI: state <= S_I_EXEC;
                        OP_J:            state <= S_JUMP;
                        OP_JAL:          state <= S_JAL;
                        default:         state <= S_ILLEGAL;
                    endcase
                end
                S_R_EXEC: state <= S_R_WB;
                S_ADDR:   state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (mem_ready) state <= S_LW_WB;
                S_MEM_WR: if (mem_ready) state <= S_FETCH;
                S_I_EXEC: state <= S_I_WB;
`ifdef ILLEGAL_OP_HALT_EN
                S_ILLEGAL: state <= S_ILLEGAL;
`else
                S_ILLEGAL: state <= S_FETCH;
`endif
                default:  state <= S_FETCH;
            endcase
        end
    end

    assign dbg_state = state;

    always_comb begin
        pc_load    = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_cntrl  = ALU_ADD;
        pc_src     = 2'b00;
        instr_done = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_load   = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                case (func)
                    FN_SUB:  alu_cntrl = ALU_SUB;
                    FN_AND:  alu_cntrl = ALU_AND;
                    FN_OR:   alu_cntrl = ALU_OR;
                    FN_SLT:  alu_cntrl = ALU_SLT;
                    FN_ADD:  alu_cntrl = ALU_ADD;
                    default: alu_cntrl = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                mdr_write = mem_ready;
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_cntrl  = ALU_SUB;
                pc_src     = 2'b01;
                pc_load    = (opcode == OP_BNE) ? !zero : zero;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cntrl = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_load    = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_load    = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_src     = 2'b11;
                pc_load    = 1'b1;
                instr_done = 1'b1;
            end
`ifdef ILLEGAL_OP_HALT_EN
            S_ILLEGAL: begin
                instr_done = 1'b0;
            end
`else
            S_ILLEGAL: begin
                instr_done = 1'b1;
            end
`endif
            default: begin
                instr_done = 1'b0;
            end
        endcase

        // Reset wins immediately: the abandoned instruction must not write anything.
        if (rst) begin
            pc_load    = 1'b0;
            ir_write   = 1'b0;
            mdr_write  = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each instruction
// into its expected per-cycle control trace; honours ILLEGAL_OP_HALT_EN when defined.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_load;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_cntrl;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctl_t;

    typedef struct packed {
        logic mr;
        logic z;
        ctl_t ctl;
    } step_t;

    localparam logic [2:0] A_AND = 3'b000;
    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b110;
    localparam logic [2:0] A_SLT = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       pc_load, i_or_d, mem_read, mem_write, ir_write, mdr_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       alu_src_a, instr_done;
    logic [2:0] alu_cntrl;
    logic [3:0] dbg_state;

    ctl_t  obs;
    step_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    multicycle_controller #(.ALU_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_load(pc_load), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_cntrl(alu_cntrl), .pc_src(pc_src), .instr_done(instr_done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign obs = {pc_load, i_or_d, mem_read, mem_write, ir_write, mdr_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_cntrl, pc_src, instr_done};

    function automatic ctl_t nop();
        ctl_t c = '0;
        c.alu_cntrl = A_ADD;
        return c;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic mr, input logic z, input ctl_t c);
        step_t s;
        s.mr  = mr;
        s.z   = z;
        s.ctl = c;
        exp_q.push_back(s);
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return A_SUB;
            6'b100100: return A_AND;
            6'b100101: return A_OR;
            6'b101010: return A_SLT;
            default:   return A_ADD;
        endcase
    endfunction

    // Expected trace of one instruction: fw fetch stalls, mw data-memory stalls, zb = zero in branch.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                  input int fw, input int mw, input logic zb);
        ctl_t c;
        for (int i = 0; i < fw; i++) begin
            c = nop(); c.mem_read = 1; c.alu_src_b = 2'b01;
            push(1'b0, rb(), c);
        end
        c = nop(); c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_load = 1;
        push(1'b1, rb(), c);
        c = nop(); c.alu_src_b = 2'b11;
        push(rb(), rb(), c);
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) begin
                    c = nop(); c.pc_src = 2'b11; c.pc_load = 1; c.instr_done = 1;
                    push(rb(), rb(), c);
                end else begin
                    c = nop(); c.alu_src_a = 1; c.alu_cntrl = r_alu(fn);
                    push(rb(), rb(), c);
                    c = nop(); c.reg_write = 1; c.reg_dst = 2'b01; c.instr_done = 1;
                    push(rb(), rb(), c);
                end
            end
            6'b100011, 6'b101011: begin
                c = nop(); c.alu_src_a = 1; c.alu_src_b = 2'b10;
                push(rb(), rb(), c);
                if (op == 6'b100011) begin
                    for (int i = 0; i < mw; i++) begin
                        c = nop(); c.mem_read = 1; c.i_or_d = 1;
                        push(1'b0, rb(), c);
                    end
                    c = nop(); c.mem_read = 1; c.i_or_d = 1; c.mdr_write = 1;
                    push(1'b1, rb(), c);
                    c = nop(); c.reg_write = 1; c.mem_to_reg = 2'b01; c.instr_done = 1;
                    push(rb(), rb(), c);
                end else begin
                    for (int i = 0; i < mw; i++) begin
                        c = nop(); c.mem_write = 1; c.i_or_d = 1;
                        push(1'b0, rb(), c);
                    end
                    c = nop(); c.mem_write = 1; c.i_or_d = 1; c.instr_done = 1;
                    push(1'b1, rb(), c);
                end
            end
            6'b000100, 6'b000101: begin
                c = nop(); c.alu_src_a = 1; c.alu_cntrl = A_SUB; c.pc_src = 2'b01;
                c.pc_load = (op == 6'b000100) ? zb : !zb; c.instr_done = 1;
                push(rb(), zb, c);
            end
            6'b001000, 6'b001010: begin
                c = nop(); c.alu_src_a = 1; c.alu_src_b = 2'b10;
                c.alu_cntrl = (op == 6'b001010) ? A_SLT : A_ADD;
                push(rb(), rb(), c);
                c = nop(); c.reg_write = 1; c.instr_done = 1;
                push(rb(), rb(), c);
            end
            6'b000010: begin
                c = nop(); c.pc_src = 2'b10; c.pc_load = 1; c.instr_done = 1;
                push(rb(), rb(), c);
            end
            6'b000011: begin
                c = nop(); c.pc_src = 2'b10; c.pc_load = 1; c.reg_write = 1;
                c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.instr_done = 1;
                push(rb(), rb(), c);
            end
            default: begin
`ifdef ILLEGAL_OP_HALT_EN
                for (int i = 0; i < 20; i++) push(1'b1, rb(), nop());
`else
                c = nop(); c.instr_done = 1;
                push(rb(), rb(), c);
`endif
            end
        endcase
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (check %0d): observed %h expected %h", tag, checks, obs, exp);
        end
    endtask

    task automatic step(input string tag, input step_t s);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = s.mr;
        zero      = s.z;
        #1;
        check(tag, s.ctl);
    endtask

    task automatic run_n(input string tag, input int n);
        step_t s;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            s = exp_q.pop_front();
            step(tag, s);
        end
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input logic zb);
        opcode = op;
        func   = fn;
        build(op, fn, fw, mw, zb);
        run_n(tag, exp_q.size());
    endtask

    // Assert rst mid-cycle; it stays high across the next rising edge and the next step releases it.
    task automatic do_reset(input string tag, input logic mr);
        ctl_t c;
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = mr;
        #1;
        c = nop(); c.mem_read = 1; c.alu_src_b = 2'b01;
        check(tag, c);
    endtask

    logic [5:0] ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                            6'b001000, 6'b001010, 6'b000010, 6'b000011};
    logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};

    initial begin
        rst = 1'b1; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        do_reset("reset_state", 1'b1);

        do_instr("add",      6'b000000, 6'b100000, 0, 0, 1'b0);
        do_instr("sub",      6'b000000, 6'b100010, 0, 0, 1'b0);
        do_instr("and",      6'b000000, 6'b100100, 1, 0, 1'b0);
        do_instr("or",       6'b000000, 6'b100101, 0, 0, 1'b0);
        do_instr("slt",      6'b000000, 6'b101010, 0, 0, 1'b0);
        do_instr("r_other",  6'b000000, 6'b000111, 0, 0, 1'b0);
        do_instr("lw_wait2", 6'b100011, 6'b000000, 0, 2, 1'b0);
        do_instr("sw_wait1", 6'b101011, 6'b000000, 0, 1, 1'b0);
        do_instr("beq_z1",   6'b000100, 6'b000000, 0, 0, 1'b1);
        do_instr("beq_z0",   6'b000100, 6'b000000, 0, 0, 1'b0);
        do_instr("bne_z1",   6'b000101, 6'b000000, 0, 0, 1'b1);
        do_instr("bne_z0",   6'b000101, 6'b000000, 0, 0, 1'b0);
        do_instr("addi",     6'b001000, 6'b000000, 0, 0, 1'b0);
        do_instr("slti",     6'b001010, 6'b000000, 2, 0, 1'b0);
        do_instr("j",        6'b000010, 6'b000000, 0, 0, 1'b0);
        do_instr("jal",      6'b000011, 6'b000000, 0, 0, 1'b0);
        do_instr("jr",       6'b000000, 6'b001000, 0, 0, 1'b0);

        // Abort a store while it is still waiting on memory.
        opcode = 6'b101011; func = '0;
        build(6'b101011, 6'b000000, 0, 3, 1'b0);
        run_n("sw_pre_abort", 4);
        exp_q.delete();
        do_reset("reset_mid_mem_wr", 1'b0);
        do_instr("add_after_abort", 6'b000000, 6'b100000, 0, 0, 1'b0);

        do_instr("illegal", 6'b111111, 6'b000000, 0, 0, 1'b0);
`ifdef ILLEGAL_OP_HALT_EN
        do_reset("reset_after_halt", 1'b1);
`endif
        do_instr("add_after_illegal", 6'b000000, 6'b100000, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
`ifndef ILLEGAL_OP_HALT_EN
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
`endif
            do_instr("random", op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
